// File: rtl/cache_pkg.sv
// Shared constants and FSM state encoding for the set-associative tag controller.
package cache_pkg;
    localparam int WAY_W         = 4;
    localparam int DEF_NUM_WAYS  = 16;
    localparam int DEF_NUM_SETS  = 128;
    localparam int DEF_TAG_WIDTH = 20;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HIT_NOTIFY,
        MISS_WAIT,
        FILL,
        RESP
    } state_t;
endpackage

// File: rtl/cache_tag_match.sv
// Parallel tag compare across all ways of one set; reports the lowest matching valid way.
module cache_tag_match
    import cache_pkg::*;
#(
    parameter int NUM_WAYS  = DEF_NUM_WAYS,
    parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
    input  logic [NUM_WAYS-1:0]                valid,
    input  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tags,
    input  logic [TAG_WIDTH-1:0]               tag,
    output logic                               hit,
    output logic [WAY_W-1:0]                   way
);

    // Scan high to low so the last assignment wins with the lowest way.
    always_comb begin
        hit = 1'b0;
        way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == tag) begin
                hit = 1'b1;
                way = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag lookup / fill controller: one request at a time, victim selection delegated to an external policy engine.
module cache_tag_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_WAYS        = DEF_NUM_WAYS,
    parameter int NUM_SETS        = DEF_NUM_SETS,
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SET_INDEX_WIDTH-1:0] req_set,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_hit,
    output logic [WAY_W-1:0]           resp_way,
    output logic                       resp_evict_valid,
    output logic [TAG_WIDTH-1:0]       resp_evict_tag,
    output logic                       pol_valid,
    output logic                       pol_hit,
    output logic                       pol_miss,
    output logic [SET_INDEX_WIDTH-1:0] pol_set_index,
    output logic [WAY_W-1:0]           pol_access_way,
    input  logic [WAY_W-1:0]           pol_victim_way,
    input  logic                       pol_victim_ready,
    output logic [31:0]                hit_cnt,
    output logic [31:0]                miss_cnt
);

    state_t state, state_nxt;

    logic [SET_INDEX_WIDTH-1:0]          set_q;
    logic [TAG_WIDTH-1:0]                tag_q;
    logic [WAY_W-1:0]                    way_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q;
    logic [TAG_WIDTH-1:0]                tag_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0]  set_tags;
    logic                                match_hit;
    logic [WAY_W-1:0]                    match_way;
    logic [WAY_W-1:0]                    victim_eff;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) set_tags[w] = tag_mem[set_q][w];
    end

    cache_tag_match #(
        .NUM_WAYS  (NUM_WAYS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_match (
        .valid (valid_q[set_q]),
        .tags  (set_tags),
        .tag   (tag_q),
        .hit   (match_hit),
        .way   (match_way)
    );

    // Out-of-range victims from the policy engine fold onto way 0.
    assign victim_eff = (32'(pol_victim_way) >= NUM_WAYS) ? '0 : pol_victim_way;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        pol_valid      = 1'b0;
        pol_hit        = 1'b0;
        pol_miss       = 1'b0;
        pol_set_index  = '0;
        pol_access_way = '0;
        resp_valid     = 1'b0;
        req_ready      = (state == IDLE) && !rst;
        case (state)
            IDLE:       if (req_valid) state_nxt = LOOKUP;
            LOOKUP:     state_nxt = match_hit ? HIT_NOTIFY : MISS_WAIT;
            HIT_NOTIFY: begin
                pol_valid      = 1'b1;
                pol_hit        = 1'b1;
                pol_set_index  = set_q;
                pol_access_way = way_q;
                state_nxt      = RESP;
            end
            MISS_WAIT: begin
                pol_valid     = 1'b1;
                pol_miss      = 1'b1;
                pol_set_index = set_q;
                if (pol_victim_ready) state_nxt = FILL;
            end
            FILL:       state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            set_q            <= '0;
            tag_q            <= '0;
            way_q            <= '0;
            valid_q          <= '0;
            hit_cnt          <= '0;
            miss_cnt         <= '0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            resp_evict_valid <= 1'b0;
            resp_evict_tag   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    set_q <= req_set;
                    tag_q <= req_tag;
                end
                LOOKUP: begin
                    way_q <= match_way;
                    if (match_hit) begin
                        resp_hit         <= 1'b1;
                        resp_way         <= match_way;
                        resp_evict_valid <= 1'b0;
                        resp_evict_tag   <= '0;
                    end
                end
                HIT_NOTIFY: hit_cnt <= hit_cnt + 32'd1;
                MISS_WAIT:  if (pol_victim_ready) way_q <= victim_eff;
                FILL: begin
                    resp_evict_valid       <= valid_q[set_q][way_q];
                    resp_evict_tag         <= valid_q[set_q][way_q] ? tag_mem[set_q][way_q] : '0;
                    valid_q[set_q][way_q]  <= 1'b1;
                    resp_hit               <= 1'b0;
                    resp_way               <= way_q;
                    miss_cnt               <= miss_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (!rst && state == FILL) tag_mem[set_q][way_q] <= tag_q;
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: directed scenarios plus randomized traffic against an array model.
module tb_cache_tag_ctrl;
    localparam int NW = 16;
    localparam int NS = 128;
    localparam int TW = 20;
    localparam int SW = 7;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [SW-1:0] req_set;
    logic [TW-1:0] req_tag;
    logic          resp_valid, resp_ready, resp_hit, resp_evict_valid;
    logic [3:0]    resp_way;
    logic [TW-1:0] resp_evict_tag;
    logic          pol_valid, pol_hit, pol_miss;
    logic [SW-1:0] pol_set_index;
    logic [3:0]    pol_access_way, pol_victim_way;
    logic          pol_victim_ready;
    logic [31:0]   hit_cnt, miss_cnt;

    cache_tag_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_evict_valid(resp_evict_valid), .resp_evict_tag(resp_evict_tag),
        .pol_valid(pol_valid), .pol_hit(pol_hit), .pol_miss(pol_miss),
        .pol_set_index(pol_set_index), .pol_access_way(pol_access_way),
        .pol_victim_way(pol_victim_way), .pol_victim_ready(pol_victim_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit            mdl_v [NS][NW];
    logic [TW-1:0] mdl_t [NS][NW];
    int            exp_hits, exp_misses;
    int            miss_cycles;
    logic          last_hit, last_ev;
    logic [3:0]    last_way;
    logic [TW-1:0] last_evtag;
    bit            tie_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mdl_v[s][w] = 1'b0;
                mdl_t[s][w] = '0;
            end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // One full transaction: model decides hit/miss, policy engine answers after d miss cycles.
    task automatic do_req(input int s, input int t, input int vic, input int d, input int hold);
        bit            ehit;
        bit            eev;
        int            eway, evic, n;
        logic [TW-1:0] etag;
        ehit = 1'b0;
        eway = 0;
        for (int w = NW - 1; w >= 0; w--)
            if (mdl_v[s][w] && mdl_t[s][w] == TW'(t)) begin ehit = 1'b1; eway = w; end
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_set   = SW'(s);
        req_tag   = TW'(t);
        tick();
        req_valid = 1'b0;
        chk("lookup_quiet", {61'd0, pol_valid, resp_valid, req_ready}, 64'd0);
        tick();
        if (ehit) begin
            chk("hit_pol", {61'd0, pol_valid, pol_hit, pol_miss}, 64'b110);
            chk("hit_pol_way", {60'd0, pol_access_way}, 64'(eway));
            chk("hit_pol_set", {57'd0, pol_set_index}, 64'(s));
            exp_hits++;
            tick();
            chk("hit_resp", {61'd0, resp_valid, resp_hit, resp_evict_valid}, 64'b110);
            chk("hit_way", {60'd0, resp_way}, 64'(eway));
        end else begin
            evic = (vic >= NW) ? 0 : vic;
            miss_cycles = 0;
            for (int c = 1; c <= d; c++) begin
                chk("miss_pol", {61'd0, pol_valid, pol_hit, pol_miss}, 64'b101);
                chk("miss_pol_set", {57'd0, pol_set_index}, 64'(s));
                if (pol_miss) miss_cycles++;
                if (c == d) begin
                    pol_victim_ready = 1'b1;
                    pol_victim_way   = 4'(vic);
                end
                tick();
                pol_victim_ready = 1'b0;
                pol_victim_way   = 4'($urandom_range(0, 15));
            end
            chk("fill_quiet", {62'd0, pol_valid, resp_valid}, 64'd0);
            eev  = mdl_v[s][evic];
            etag = eev ? mdl_t[s][evic] : '0;
            mdl_v[s][evic] = 1'b1;
            mdl_t[s][evic] = TW'(t);
            exp_misses++;
            tick();
            chk("miss_resp", {61'd0, resp_valid, resp_hit, resp_evict_valid}, {61'd0, 2'b10, eev});
            chk("miss_way", {60'd0, resp_way}, 64'(evic));
            chk("miss_evict_tag", {44'd0, resp_evict_tag}, {44'd0, etag});
        end
        chk("hit_cnt", {32'd0, hit_cnt}, 64'(exp_hits));
        chk("miss_cnt", {32'd0, miss_cnt}, 64'(exp_misses));
        chk("resp_pol_quiet", {63'd0, pol_valid}, 64'd0);
        last_hit   = resp_hit;
        last_way   = resp_way;
        last_ev    = resp_evict_valid;
        last_evtag = resp_evict_tag;
        for (int h = 0; h < hold; h++) begin
            chk("stall_req_ready", {62'd0, resp_valid, req_ready}, 64'b10);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = tie_rdy;
        chk("idle_after_resp", {62'd0, resp_valid, req_ready}, 64'b01);
    endtask

    // Continuous checks: policy quiet gap between transactions and stalled-response stability.
    initial begin
        int            low_run;
        bit            seen, prev_pv, stalled;
        logic [26:0]   snap;
        low_run = 0; seen = 1'b0; prev_pv = 1'b0; stalled = 1'b0; snap = '0;
        forever begin
            @(negedge clk);
            if (pol_valid && !prev_pv && seen)
                chk("pol_gap_ge2", {63'd0, (low_run >= 2)}, 64'd1);
            if (pol_valid) begin low_run = 0; seen = 1'b1; end
            else low_run++;
            prev_pv = pol_valid;
            if (stalled)
                chk("resp_stable", {37'd0, resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag},
                    {37'd0, 1'b1, snap[25:0]});
            stalled = resp_valid && !resp_ready && !rst;
            snap    = {1'b1, resp_hit, resp_way, resp_evict_valid, resp_evict_tag};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0; resp_ready = 1'b0;
        pol_victim_way = '0; pol_victim_ready = 1'b0; tie_rdy = 1'b0;
        clear_model();
        tick(); tick(); tick();
        chk("reset_outputs", {4'd0, req_ready, resp_valid, pol_valid, pol_hit, pol_miss, resp_hit, resp_evict_valid, resp_way},
            64'd0);
        chk("reset_counters", {hit_cnt, miss_cnt}, 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_ready", {63'd0, req_ready}, 64'd1);

        // Cold miss, victim after 4 cycles
        do_req(5, 'h12, 0, 4, 0);
        chk("cold_miss_cycles", 64'(miss_cycles), 64'd4);
        chk("cold_resp", {58'd0, last_hit, last_ev, last_way}, 64'd0);
        chk("cold_miss_cnt", {32'd0, miss_cnt}, 64'd1);

        // Repeat hits way 0
        do_req(5, 'h12, 9, 1, 0);
        chk("repeat_hit", {59'd0, last_hit, last_way}, 64'h10);
        chk("repeat_hit_cnt", {32'd0, hit_cnt}, 64'd1);

        // Fill whole set, then displace way 3
        for (int i = 0; i < NW; i++) do_req(5, i, i, 1, 0);
        do_req(5, 'h40, 3, 2, 0);
        chk("evict_valid", {63'd0, last_ev}, 64'd1);
        chk("evict_tag", {44'd0, last_evtag}, 64'h3);
        do_req(5, 'h03, 7, 1, 0);
        chk("evicted_tag_misses", {63'd0, last_hit}, 64'd0);

        // Stalled response on a hit
        do_req(5, 'h40, 0, 1, 5);

        // Back-to-back misses, response always accepted
        tie_rdy = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_req(6, 'h50 + i, i, 1, 0);
        tie_rdy = 1'b0; resp_ready = 1'b0;

        // Reset while waiting for a victim; the victim pulse must be ignored
        req_valid = 1'b1; req_set = SW'(9); req_tag = TW'('h77);
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_reset_miss_wait", {63'd0, pol_miss}, 64'd1);
        tick();
        rst = 1'b1; pol_victim_ready = 1'b1; pol_victim_way = 4'd2;
        tick();
        rst = 1'b0; pol_victim_ready = 1'b0;
        #1;
        chk("mid_reset_outputs", {19'd0, pol_valid, pol_hit, pol_miss, pol_set_index, pol_access_way,
            resp_valid, resp_hit, resp_way, resp_evict_valid, resp_evict_tag}, 64'd0);
        chk("mid_reset_counters", {hit_cnt, miss_cnt}, 64'd0);
        chk("mid_reset_ready", {63'd0, req_ready}, 64'd1);
        clear_model();
        do_req(5, 'h12, 1, 1, 0);
        chk("post_reset_miss", {63'd0, last_hit}, 64'd0);

        // Randomized traffic over a few sets so hits and evictions both occur
        for (int i = 0; i < 150; i++)
            do_req($urandom_range(0, 3), $urandom_range(0, 23), $urandom_range(0, 15),
                   $urandom_range(1, 3), $urandom_range(0, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_tag_ctrl.md
CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 The block SHALL expose parameters NUM_WAYS (default 16, number of ways per set), NUM_SETS (default 128, number of sets) and TAG_WIDTH (default 20, tag bits per entry).
REQ-002 The block SHALL expose parameter SET_INDEX_WIDTH (default clog2(NUM_SETS), set index bits).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  lookup request present.
REQ-006 req_ready  output  1  block can accept a request; equals (state==IDLE && !rst).
REQ-007 req_set  input  SET_INDEX_WIDTH  set index of the request.
REQ-008 req_tag  input  TAG_WIDTH  tag of the request.
REQ-009 resp_valid  output  1  response present; held until resp_ready.
REQ-010 resp_ready  input  1  consumer accepts the response.
REQ-011 resp_hit  output  1  1 = hit, 0 = miss-and-fill.
REQ-012 resp_way  output  4  way that was hit or filled.
REQ-013 resp_evict_valid / resp_evict_tag  output  1 / TAG_WIDTH  a valid line was displaced, and its tag.
REQ-014 pol_valid, pol_hit, pol_miss  output  1 each  qualifiers driven to the replacement-policy engine.
REQ-015 pol_set_index  output  SET_INDEX_WIDTH  set index driven to the policy engine.
REQ-016 pol_access_way  output  4  way index driven to the policy engine.
REQ-017 pol_victim_way  input  4  victim way returned by the policy engine.
REQ-018 pol_victim_ready  input  1  victim way is valid this cycle.
REQ-019 hit_cnt, miss_cnt  output  32 each  wrapping event counters.

Function
REQ-020 Storage SHALL be a valid bit plus TAG_WIDTH tag per [set][way].
REQ-021 FSM states SHALL be IDLE, LOOKUP, HIT_NOTIFY, MISS_WAIT, FILL, RESP.
REQ-022 IDLE: on req_valid && req_ready, the block SHALL capture req_set/req_tag and go to LOOKUP.
REQ-023 LOOKUP: the block SHALL compare the captured tag against all valid ways of the set; hit selects the lowest matching way; go to HIT_NOTIFY on hit, MISS_WAIT on miss.
REQ-024 HIT_NOTIFY: pol_valid=1, pol_hit=1, pol_miss=0, pol_access_way=hit way for exactly one cycle; hit_cnt+1; go to RESP.
REQ-025 MISS_WAIT: pol_valid=1, pol_miss=1, pol_hit=0 held every cycle until pol_victim_ready=1; the block SHALL register pol_victim_way on that cycle and go to FILL.
REQ-026 pol_set_index SHALL equal the captured set in HIT_NOTIFY and MISS_WAIT; pol_* qualifiers SHALL be 0 in all other states.
REQ-027 MISS_WAIT has no timeout; it SHALL wait indefinitely.
REQ-028 FILL: resp_evict_valid/resp_evict_tag SHALL latch the old valid/tag of the victim way.
REQ-029 FILL: the block SHALL write valid=1 and the captured tag into the victim way; miss_cnt+1; go to RESP.
REQ-030 RESP: resp_valid=1 with stable fields until resp_ready; then go to IDLE.
REQ-031 The RESP/IDLE path guarantees pol_valid=0 for at least two cycles between consecutive policy transactions.
REQ-032 On a hit, resp_evict_valid SHALL be 0.
REQ-033 Minimum latency, accept to resp_valid: hit 3 cycles; miss 3 cycles plus victim wait.
REQ-034 Counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-035 A victim way ≥ NUM_WAYS SHALL be treated as way 0.

Reset
REQ-036 When rst=1 at an edge, from any state including MISS_WAIT, the block SHALL go to IDLE.
REQ-037 Reset SHALL clear all valid bits and zero hit_cnt, miss_cnt, and every resp_* and pol_* output.
REQ-038 A victim_ready arriving during reset SHALL be ignored.

Structure
REQ-039 A package cache_pkg SHALL hold the FSM state enum and the shared way/set width constants.
REQ-040 A combinational sub-module cache_tag_match (valid vector and tags in; hit and way out) SHALL implement the compare.

Verification
REQ-041 Cold miss: set 5, tag 0x12; policy model asserts pol_victim_ready with way 0 after 4 cycles. Required: pol_miss held 4 cycles; resp_hit=0, resp_way=0, evict_valid=0; miss_cnt=1.
REQ-042 Repeat set 5, tag 0x12. Required: one-cycle pol_hit with access_way 0; resp_hit=1, resp_way=0 three cycles after accept; hit_cnt=1.
REQ-043 Fill set 5 ways 0-15 with tags 0x00-0x0F, then request tag 0x40 with model victim 3. Required: resp_evict_valid=1, resp_evict_tag=0x03; a later lookup of 0x03 misses.
REQ-044 Back-to-back misses with resp_ready tied 1. Required: pol_valid low for at least 2 cycles between transactions.
REQ-045 Hold resp_ready=0 for 5 cycles. Required: resp fields stable throughout and req_ready=0.
REQ-046 Assert rst during MISS_WAIT. Required: state IDLE, all pol_*/resp_* at 0, counters 0; a following lookup of any tag misses.
